regfile_nport: RTL and testbench



---
 rtl/regfile_nport.sv | 150 +++++++++++++++
 tb/tb_regfile_nport.sv | 273 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/regfile_nport.sv
// regfile_nport: N_RD-port registered-read register file with one write port,
// optional same-edge write forwarding, optional hardwired-zero register 0, and
// a valid/ready dump engine that streams every register without stalling reads.
module regfile_nport #(
    parameter int LEN      = 32,
    parameter int NB_REG   = 32,
    parameter int NB_ADDR  = 5,
    parameter int N_RD     = 2,
    parameter int ZERO_REG = 1,
    parameter int BYPASS   = 1
) (
    input  logic                    i_clk,
    input  logic                    i_rst,
    input  logic                    i_enable,
    input  logic                    i_RegWrite,
    input  logic [NB_ADDR-1:0]      i_write_register,
    input  logic [LEN-1:0]          i_write_data,
    input  logic [N_RD*NB_ADDR-1:0] i_read_register,
    output logic [N_RD*LEN-1:0]     o_read_data,
    input  logic                    i_dump_start,
    input  logic                    i_dump_ready,
    output logic                    o_dump_valid,
    output logic [NB_ADDR-1:0]      o_dump_addr,
    output logic [LEN-1:0]          o_dump_data,
    output logic                    o_dump_last,
    output logic                    o_dump_busy
);

    typedef enum logic {
        ST_IDLE,
        ST_SEND
    } dump_state_t;

    localparam logic [NB_ADDR-1:0] LAST_ADDR = NB_ADDR'(NB_REG - 1);

    logic [LEN-1:0]      r_regs [NB_REG];
    logic [N_RD*LEN-1:0] r_read_data;

    dump_state_t         r_dump_state;
    logic                r_dump_valid;
    logic [NB_ADDR-1:0]  r_dump_addr;
    logic [LEN-1:0]      r_dump_data;
    logic                r_dump_last;
    logic                r_dump_busy;

    logic                w_we;
    logic [NB_ADDR-1:0]  w_dump_next_addr;
    logic [NB_ADDR-1:0]  w_dump_fetch_addr;
    logic [LEN-1:0]      w_dump_fetch_data;
    logic [N_RD*LEN-1:0] w_read_next;

    // A write only lands when the pipeline runs; register 0 may be read-only.
    assign w_we = i_enable && i_RegWrite &&
                  !((ZERO_REG != 0) && (i_write_register == '0));

    // Value a reader sees at this edge: zero register, forwarded write, or array.
    function automatic logic [LEN-1:0] f_fetch(input logic [NB_ADDR-1:0] a);
        if ((ZERO_REG != 0) && (a == '0))
            return '0;
        else if ((BYPASS != 0) && w_we && (i_write_register == a))
            return i_write_data;
        else
            return r_regs[a];
    endfunction

    assign w_dump_next_addr = r_dump_addr + NB_ADDR'(1);

    // Next read-port values and the next dump beat source.
    always_comb begin
        w_read_next = '0;
        for (int unsigned k = 0; k < N_RD; k++) begin
            w_read_next[k*LEN +: LEN] = f_fetch(i_read_register[k*NB_ADDR +: NB_ADDR]);
        end
        w_dump_fetch_addr = (r_dump_state == ST_IDLE) ? '0 : w_dump_next_addr;
        w_dump_fetch_data = f_fetch(w_dump_fetch_addr);
    end

    // Register array: synchronous clear, single write port.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            for (int unsigned i = 0; i < NB_REG; i++) begin
                r_regs[i] <= '0;
            end
        end else if (w_we) begin
            r_regs[i_write_register] <= i_write_data;
        end
    end

    // Registered read ports; hold their value while the pipeline is stalled.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_read_data <= '0;
        end else if (i_enable) begin
            r_read_data <= w_read_next;
        end
    end

    // Dump engine: each beat is captured at load time and held until accepted.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_dump_state <= ST_IDLE;
            r_dump_valid <= 1'b0;
            r_dump_addr  <= '0;
            r_dump_data  <= '0;
            r_dump_last  <= 1'b0;
            r_dump_busy  <= 1'b0;
        end else begin
            case (r_dump_state)
                ST_IDLE: begin
                    if (i_dump_start) begin
                        r_dump_state <= ST_SEND;
                        r_dump_valid <= 1'b1;
                        r_dump_busy  <= 1'b1;
                        r_dump_addr  <= '0;
                        r_dump_data  <= w_dump_fetch_data;
                        r_dump_last  <= (LAST_ADDR == '0);
                    end
                end
                ST_SEND: begin
                    if (i_dump_ready) begin
                        if (r_dump_last) begin
                            r_dump_state <= ST_IDLE;
                            r_dump_valid <= 1'b0;
                            r_dump_busy  <= 1'b0;
                            r_dump_last  <= 1'b0;
                        end else begin
                            r_dump_addr  <= w_dump_next_addr;
                            r_dump_data  <= w_dump_fetch_data;
                            r_dump_last  <= (w_dump_next_addr == LAST_ADDR);
                        end
                    end
                end
                default: begin
                    r_dump_state <= ST_IDLE;
                    r_dump_valid <= 1'b0;
                    r_dump_busy  <= 1'b0;
                    r_dump_last  <= 1'b0;
                end
            endcase
        end
    end

    assign o_read_data  = r_read_data;
    assign o_dump_valid = r_dump_valid;
    assign o_dump_addr  = r_dump_addr;
    assign o_dump_data  = r_dump_data;
    assign o_dump_last  = r_dump_last;
    assign o_dump_busy  = r_dump_busy;

endmodule

// File: tb/tb_regfile_nport.sv
// tb_regfile_nport: table vectors, randomized reads/writes against an array
// model, and hand-written dump sequences (backpressure, reset mid-dump).
module tb_regfile_nport;

    localparam int LEN     = 32;
    localparam int NB_ADDR = 5;
    localparam int NB_REG  = 32;
    localparam int N_RD    = 2;

    logic                    clk = 1'b0;
    logic                    rst = 1'b1;
    logic                    en = 1'b0;
    logic                    rw = 1'b0;
    logic [NB_ADDR-1:0]      wa = '0;
    logic [LEN-1:0]          wd = '0;
    logic [N_RD*NB_ADDR-1:0] ra = '0;
    logic                    start = 1'b0;
    logic                    ready = 1'b0;

    logic [N_RD*LEN-1:0] rd, rd_nb;
    logic                dv, dl, db, dv_nb, dl_nb, db_nb;
    logic [NB_ADDR-1:0]  da, da_nb;
    logic [LEN-1:0]      dd, dd_nb;

    always #5 clk = ~clk;

    regfile_nport #(.LEN(LEN), .NB_REG(NB_REG), .NB_ADDR(NB_ADDR), .N_RD(N_RD),
                    .ZERO_REG(1), .BYPASS(1)) u_dut (
        .i_clk(clk), .i_rst(rst), .i_enable(en), .i_RegWrite(rw),
        .i_write_register(wa), .i_write_data(wd), .i_read_register(ra),
        .o_read_data(rd), .i_dump_start(start), .i_dump_ready(ready),
        .o_dump_valid(dv), .o_dump_addr(da), .o_dump_data(dd),
        .o_dump_last(dl), .o_dump_busy(db)
    );

    regfile_nport #(.LEN(LEN), .NB_REG(NB_REG), .NB_ADDR(NB_ADDR), .N_RD(N_RD),
                    .ZERO_REG(1), .BYPASS(0)) u_dut_nb (
        .i_clk(clk), .i_rst(rst), .i_enable(en), .i_RegWrite(rw),
        .i_write_register(wa), .i_write_data(wd), .i_read_register(ra),
        .o_read_data(rd_nb), .i_dump_start(start), .i_dump_ready(ready),
        .o_dump_valid(dv_nb), .o_dump_addr(da_nb), .o_dump_data(dd_nb),
        .o_dump_last(dl_nb), .o_dump_busy(db_nb)
    );

    int n_vec = 0;
    int n_err = 0;

    // Reference: the register contents and what each port should show.
    logic [LEN-1:0] mem [NB_REG];
    logic [LEN-1:0] exp_rd [N_RD];
    logic [LEN-1:0] exp_nb [N_RD];

    typedef struct {
        logic           en;
        logic           we;
        logic [4:0]     wa;
        logic [31:0]    wd;
        logic [4:0]     a0;
        logic [4:0]     a1;
        logic [31:0]    e0;
        logic [31:0]    e1;
        logic [31:0]    n0;
        logic [31:0]    n1;
    } vec_t;

    vec_t tbl [10];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Advance the model by one edge using the inputs currently driven.
    task automatic model_edge();
        logic       we;
        logic [4:0] a;
        we = en && rw && (wa != 5'd0);
        if (rst) begin
            for (int i = 0; i < NB_REG; i++) mem[i] = '0;
            for (int k = 0; k < N_RD; k++) begin
                exp_rd[k] = '0;
                exp_nb[k] = '0;
            end
            return;
        end
        if (en) begin
            for (int k = 0; k < N_RD; k++) begin
                a = ra[k*NB_ADDR +: NB_ADDR];
                exp_nb[k] = (a == 5'd0) ? 32'd0 : mem[a];
                exp_rd[k] = (a == 5'd0) ? 32'd0 : ((we && wa == a) ? wd : mem[a]);
            end
        end
        if (we) mem[wa] = wd;
    endtask

    task automatic tick();
        model_edge();
        @(posedge clk);
        #1;
    endtask

    task automatic check_reads(input string tag);
        chk({tag, "_p0"},    rd[31:0],     exp_rd[0]);
        chk({tag, "_p1"},    rd[63:32],    exp_rd[1]);
        chk({tag, "_nb_p0"}, rd_nb[31:0],  exp_nb[0]);
        chk({tag, "_nb_p1"}, rd_nb[63:32], exp_nb[1]);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int b;
        int c;
        bit wrote;
        logic [4:0] a0, a1;

        tbl[0] = '{1'b1, 1'b1, 5'd7, 32'hDEADBEEF, 5'd0, 5'd0, 32'h0, 32'h0, 32'h0, 32'h0};
        tbl[1] = '{1'b1, 1'b0, 5'd0, 32'h0, 5'd0, 5'd7, 32'h0, 32'hDEADBEEF, 32'h0, 32'hDEADBEEF};
        tbl[2] = '{1'b1, 1'b1, 5'd0, 32'h1234, 5'd0, 5'd0, 32'h0, 32'h0, 32'h0, 32'h0};
        tbl[3] = '{1'b1, 1'b0, 5'd0, 32'h0, 5'd0, 5'd0, 32'h0, 32'h0, 32'h0, 32'h0};
        tbl[4] = '{1'b1, 1'b1, 5'd3, 32'hA5A5A5A5, 5'd3, 5'd3, 32'hA5A5A5A5, 32'hA5A5A5A5, 32'h0, 32'h0};
        tbl[5] = '{1'b1, 1'b0, 5'd0, 32'h0, 5'd3, 5'd3, 32'hA5A5A5A5, 32'hA5A5A5A5, 32'hA5A5A5A5, 32'hA5A5A5A5};
        tbl[6] = '{1'b1, 1'b1, 5'd5, 32'h55, 5'd7, 5'd3, 32'hDEADBEEF, 32'hA5A5A5A5, 32'hDEADBEEF, 32'hA5A5A5A5};
        tbl[7] = '{1'b0, 1'b1, 5'd5, 32'h999, 5'd1, 5'd2, 32'hDEADBEEF, 32'hA5A5A5A5, 32'hDEADBEEF, 32'hA5A5A5A5};
        tbl[8] = '{1'b1, 1'b0, 5'd0, 32'h0, 5'd5, 5'd5, 32'h55, 32'h55, 32'h55, 32'h55};
        tbl[9] = '{1'b1, 1'b1, 5'd0, 32'hFFFF, 5'd0, 5'd0, 32'h0, 32'h0, 32'h0, 32'h0};

        // Reset, then sweep every address on both ports.
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("rst_valid", 32'(dv), 32'd0);
        chk("rst_busy",  32'(db), 32'd0);
        chk("rst_last",  32'(dl), 32'd0);
        chk("rst_addr",  32'(da), 32'd0);
        chk("rst_data",  dd, 32'd0);
        check_reads("rst");
        en = 1'b1;
        for (int i = 0; i < NB_REG; i++) begin
            ra = {5'(31 - i), 5'(i)};
            tick();
            check_reads("sweep");
            chk("sweep_busy", 32'(db), 32'd0);
        end

        // Directed table: write/read, zero register, bypass, stall.
        foreach (tbl[i]) begin
            en = tbl[i].en;
            rw = tbl[i].we;
            wa = tbl[i].wa;
            wd = tbl[i].wd;
            ra = {tbl[i].a1, tbl[i].a0};
            tick();
            chk("tbl_p0",    rd[31:0],     tbl[i].e0);
            chk("tbl_p1",    rd[63:32],    tbl[i].e1);
            chk("tbl_nb_p0", rd_nb[31:0],  tbl[i].n0);
            chk("tbl_nb_p1", rd_nb[63:32], tbl[i].n1);
        end

        // Randomized traffic, reads often aimed at the write address.
        for (int i = 0; i < 400; i++) begin
            en = ($urandom_range(0, 7) != 0);
            rw = 1'($urandom_range(0, 1));
            wa = 5'($urandom);
            wd = $urandom;
            a0 = ($urandom_range(0, 2) == 0) ? wa : 5'($urandom);
            a1 = ($urandom_range(0, 2) == 0) ? wa : 5'($urandom);
            ra = {a1, a0};
            tick();
            check_reads("rnd");
        end

        // Dump with 1-0-0 backpressure over a preloaded array.
        en = 1'b1;
        rw = 1'b1;
        ra = '0;
        for (int k = 0; k < NB_REG; k++) begin
            wa = 5'(k);
            wd = 32'(k * 32'h11);
            tick();
        end
        rw = 1'b0;
        start = 1'b1;
        tick();
        start = 1'b0;
        chk("bp_busy", 32'(db), 32'd1);
        b = 0;
        c = 0;
        wrote = 1'b0;
        while (b < NB_REG && c < 200) begin
            chk("bp_valid", 32'(dv), 32'd1);
            chk("bp_addr",  32'(da), 32'(b));
            chk("bp_data",  dd, 32'(b * 32'h11));
            chk("bp_last",  32'(dl), 32'(b == NB_REG - 1));
            ready = (c % 3 == 0);
            if (b == 10 && !ready && !wrote) begin
                rw = 1'b1;
                wa = 5'd10;
                wd = 32'hFFFF;
                wrote = 1'b1;
            end else begin
                rw = 1'b0;
            end
            tick();
            if (ready) b++;
            c++;
        end
        chk("bp_beats", 32'(b), 32'(NB_REG));
        ready = 1'b0;
        rw = 1'b0;
        chk("bp_end_valid", 32'(dv), 32'd0);
        chk("bp_end_busy",  32'(db), 32'd0);
        ra = {5'd0, 5'd10};
        tick();
        chk("bp_r10", rd[31:0], 32'hFFFF);

        // Reset in the middle of a dump, then dump the cleared array.
        ready = 1'b1;
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int i = 0; i <= 12; i++) begin
            chk("rmd_addr", 32'(da), 32'(i));
            tick();
        end
        chk("rmd_addr13", 32'(da), 32'd13);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("rmd_valid", 32'(dv), 32'd0);
        chk("rmd_busy",  32'(db), 32'd0);
        chk("rmd_addr",  32'(da), 32'd0);
        chk("rmd_data",  dd, 32'd0);
        for (int i = 0; i < NB_REG; i++) begin
            ra = {5'(31 - i), 5'(i)};
            tick();
            check_reads("rmd_sweep");
        end
        start = 1'b1;
        tick();
        start = 1'b0;
        b = 0;
        c = 0;
        while (b < NB_REG && c < 100) begin
            chk("zd_valid", 32'(dv), 32'd1);
            chk("zd_addr",  32'(da), 32'(b));
            chk("zd_data",  dd, 32'd0);
            chk("zd_last",  32'(dl), 32'(b == NB_REG - 1));
            tick();
            b++;
            c++;
        end
        chk("zd_beats", 32'(b), 32'(NB_REG));
        chk("zd_busy",  32'(db), 32'd0);
        start = 1'b1;
        tick();
        start = 1'b0;
        chk("restart_valid", 32'(dv), 32'd1);
        chk("restart_addr",  32'(da), 32'd0);
        chk("restart_busy",  32'(db), 32'd1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
